// File: rtl/rotating_pattern_gen.sv
// Rotating seven-segment pattern generator: a prescaled position counter walks a
// half-square (or, with ROTATING_CHASE_EN defined, a perimeter chase) across the display.
module rotating_pattern_gen #(
    parameter int DIGITS = 8,
    parameter int TICK_W = 24
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic                            cw,
    input  logic [1:0]                      speed,
    input  logic                            mode,
    output logic [6:0]                      CA,
    output logic [DIGITS-1:0]               AN,
    output logic [$clog2(2*DIGITS+4)-1:0]   pos,
    output logic                            wrap
);
    localparam int PW = $clog2(2*DIGITS+4);

    localparam logic [6:0] SEG_UPPER = 7'b0011100;
    localparam logic [6:0] SEG_LOWER = 7'b0100011;
    localparam logic [6:0] SEG_A     = 7'b1111110;
    localparam logic [6:0] SEG_B     = 7'b1111101;
    localparam logic [6:0] SEG_C     = 7'b1111011;
    localparam logic [6:0] SEG_D     = 7'b1110111;
    localparam logic [6:0] SEG_E     = 7'b1101111;
    localparam logic [6:0] SEG_F     = 7'b1011111;

    logic [TICK_W-1:0] cnt_q, cnt_d, tick_mask;
    logic [PW-1:0]     pos_q, pos_d, last_pos;
    logic              wrap_q, wrap_d;
    logic              tick, mode_chg, chase;
    logic [6:0]        seg;
    int                p_int;
    int                an_pos;

`ifdef ROTATING_CHASE_EN
    logic mode_q;
    assign chase    = mode_q;
    assign mode_chg = (mode_q != mode);
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign chase       = 1'b0;
    assign mode_chg    = 1'b0;
`endif

    // Faster speeds look at fewer low bits, so the period shrinks without clearing cnt.
    assign tick_mask = {TICK_W{1'b1}} >> speed;
    assign tick      = en && ((cnt_q & tick_mask) == tick_mask);
    assign last_pos  = chase ? PW'(2*DIGITS+3) : PW'(2*DIGITS-1);

    always_comb begin
        cnt_d  = cnt_q;
        pos_d  = pos_q;
        wrap_d = 1'b0;
        if (mode_chg) begin
            cnt_d = '0;
            pos_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + TICK_W'(1);
            if (tick) begin
                if (cw) begin
                    if (pos_q == last_pos) begin
                        pos_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        pos_d = pos_q + PW'(1);
                    end
                end else begin
                    if (pos_q == '0) begin
                        pos_d  = last_pos;
                        wrap_d = 1'b1;
                    end else begin
                        pos_d = pos_q - PW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            pos_q  <= '0;
            wrap_q <= 1'b0;
`ifdef ROTATING_CHASE_EN
            mode_q <= mode;
`endif
        end else begin
            cnt_q  <= cnt_d;
            pos_q  <= pos_d;
            wrap_q <= wrap_d;
`ifdef ROTATING_CHASE_EN
            mode_q <= mode;
`endif
        end
    end

    assign p_int = int'(pos_q);

    // an_pos is the AN bit index to pull low; AN[DIGITS-1] is the leftmost digit.
    always_comb begin
        seg    = SEG_UPPER;
        an_pos = DIGITS - 1;
        if (chase) begin
            if (p_int < DIGITS) begin
                seg    = SEG_A;
                an_pos = DIGITS - 1 - p_int;
            end else if (p_int == DIGITS) begin
                seg    = SEG_B;
                an_pos = 0;
            end else if (p_int == DIGITS + 1) begin
                seg    = SEG_C;
                an_pos = 0;
            end else if (p_int <= 2*DIGITS + 1) begin
                seg    = SEG_D;
                an_pos = p_int - DIGITS - 2;
            end else if (p_int == 2*DIGITS + 2) begin
                seg    = SEG_E;
                an_pos = DIGITS - 1;
            end else begin
                seg    = SEG_F;
                an_pos = DIGITS - 1;
            end
        end else if (p_int < DIGITS) begin
            seg    = SEG_UPPER;
            an_pos = DIGITS - 1 - p_int;
        end else begin
            seg    = SEG_LOWER;
            an_pos = p_int - DIGITS;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_an
            assign AN[gi] = (an_pos != gi);
        end
    endgenerate

    assign CA   = seg;
    assign pos  = pos_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_rotating_pattern_gen.sv
// Randomized bench for rotating_pattern_gen (DIGITS=4, TICK_W=4) against a behavioural model.
module tb_rotating_pattern_gen;
    localparam int D  = 4;
    localparam int TW = 4;
`ifdef ROTATING_CHASE_EN
    localparam bit CHASE = 1'b1;
`else
    localparam bit CHASE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, en, cw, mode;
    logic [1:0] speed;
    logic [6:0] CA;
    logic [D-1:0] AN;
    logic [3:0] pos;
    logic       wrap;

    int n_checks = 0;
    int n_bad    = 0;

    // model state
    int m_cnt  = 0;
    int m_pos  = 0;
    bit m_wrap = 1'b0;
    bit m_mode = 1'b0;

    rotating_pattern_gen #(.DIGITS(D), .TICK_W(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .cw    (cw),
        .speed (speed),
        .mode  (mode),
        .CA    (CA),
        .AN    (AN),
        .pos   (pos),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, got, exp);
        end
    endtask

    // Expected display from the pattern rules, expressed as "digit counted from the left".
    task automatic exp_disp(input int p, input bit chase, output logic [6:0] ca, output logic [D-1:0] an);
        int left;
        if (!chase) begin
            if (p < D) begin ca = 7'b0011100; left = p;         end
            else       begin ca = 7'b0100011; left = 2*D-1-p;   end
        end else begin
            if (p < D)             begin ca = 7'b1111110; left = p;       end
            else if (p == D)       begin ca = 7'b1111101; left = D-1;     end
            else if (p == D+1)     begin ca = 7'b1111011; left = D-1;     end
            else if (p <= 2*D+1)   begin ca = 7'b1110111; left = 2*D+1-p; end
            else if (p == 2*D+2)   begin ca = 7'b1101111; left = 0;       end
            else                   begin ca = 7'b1011111; left = 0;       end
        end
        an = '1;
        an[D-1-left] = 1'b0;
    endtask

    task automatic model_edge();
        int per, len, sp;
        sp  = int'(speed);
        len = (CHASE && m_mode) ? 2*D+4 : 2*D;
        if (!rst_n) begin
            m_cnt = 0; m_pos = 0; m_wrap = 1'b0; m_mode = mode;
        end else if (CHASE && (m_mode != mode)) begin
            m_cnt = 0; m_pos = 0; m_wrap = 1'b0; m_mode = mode;
        end else if (en) begin
            per = 1 << (TW - sp);
            if ((m_cnt % per) == per - 1) begin
                if (cw) begin
                    m_wrap = (m_pos == len - 1);
                    m_pos  = (m_pos + 1) % len;
                end else begin
                    m_wrap = (m_pos == 0);
                    m_pos  = (m_pos + len - 1) % len;
                end
            end else begin
                m_wrap = 1'b0;
            end
            m_cnt = (m_cnt + 1) % (1 << TW);
        end else begin
            m_wrap = 1'b0;
        end
    endtask

    task automatic step_cycle();
        logic [6:0]   eca;
        logic [D-1:0] ean;
        int           prev;
        prev = m_pos;
        @(posedge clk);
        model_edge();
        #1;
        exp_disp(m_pos, CHASE && m_mode, eca, ean);
        check_eq("pos",  32'(pos),  32'(m_pos));
        check_eq("wrap", 32'(wrap), 32'(m_wrap));
        check_eq("ca",   32'(CA),   32'(eca));
        check_eq("an",   32'(AN),   32'(ean));
        check_eq("an_onehot", 32'($countones(~AN)), 32'd1);
        if (prev != m_pos || m_wrap)
            $display("step t=%0t pos=%0d ca=%b an=%b wrap=%b", $time, pos, CA, AN, wrap);
    endtask

    task automatic run_until_pos(input int target, input int budget);
        int k;
        k = 0;
        while (m_pos != target && k < budget) begin
            step_cycle();
            k++;
        end
        check_eq("reach_pos", 32'(pos), 32'(target));
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; cw = 1'b1; speed = 2'd3; mode = 1'b0;
        repeat (2) step_cycle();
        rst_n = 1'b1; en = 1'b1;
        repeat (18) step_cycle();          // full clockwise lap and wrap

        cw = 1'b0;
        run_until_pos(0, 40);
        repeat (6) step_cycle();           // backward through the 0 -> 7 wrap

        cw = 1'b1; speed = 2'd0;
        repeat (40) step_cycle();
        speed = 2'd2;
        repeat (10) step_cycle();

        speed = 2'd3;
        run_until_pos(3, 40);
        en = 1'b0;
        repeat (8) step_cycle();
        en = 1'b1;
        repeat (6) step_cycle();

        run_until_pos(6, 40);
        rst_n = 1'b0;
        step_cycle();
        rst_n = 1'b1;
        repeat (4) step_cycle();

        if (CHASE) begin
            run_until_pos(5, 40);
            mode = 1'b1;
            repeat (30) step_cycle();      // whole perimeter and back to 0
            mode = 1'b0;
            repeat (4) step_cycle();
        end

        for (int i = 0; i < 600; i++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0)  cw = ~cw;
            if ($urandom_range(0, 19) == 0) speed = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) mode = ~mode;
            rst_n = ($urandom_range(0, 99) != 0);
            step_cycle();
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
